// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and sizing for the FPU result queue
package fpu_pkg;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    localparam int FPU_RESULT_QUEUE_DEPTH = 8;
    localparam int FPU_DATA_WIDTH         = 32;
    localparam int FPU_FLAG_WIDTH         = $bits(fpu_flags_t);

endpackage

// File: rtl/fpu_result_queue_if.sv
// rtl/fpu_result_queue_if.sv - issue, result and consumer handshakes of the FPU result queue
interface fpu_result_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  issue_fire;
    logic                  result_valid;
    logic [DATA_WIDTH-1:0] result;
    logic [FLAG_WIDTH-1:0] result_flags;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [FLAG_WIDTH-1:0] out_flags;

    modport master (
        output in_valid, result_valid, result, result_flags, out_ready,
        input  in_ready, issue_fire, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, result_valid, result, result_flags, out_ready,
        output in_ready, issue_fire, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fpu_result_queue_fifo.sv
// rtl/fpu_result_queue_fifo.sv - synchronous FIFO with registered head, drops pushes when full
module fpu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_next = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head is refreshed only on queue activity; when the queue is about to
    // hold just the incoming word, it bypasses the not-yet-written memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            if (push_ok & ~pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok & ~push_ok) begin
                count <= count - CW'(1);
            end
            if (push_ok | pop_ok) begin
                head <= (push_ok && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
            end
        end
    end
endmodule

// File: rtl/fpu_result_queue.sv
// rtl/fpu_result_queue.sv - credit-gated issue and result buffering at the FPU pipeline output
module fpu_result_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH      = FPU_RESULT_QUEUE_DEPTH,
    parameter int DATA_WIDTH = FPU_DATA_WIDTH,
    parameter int FLAG_WIDTH = FPU_FLAG_WIDTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    fpu_result_queue_if.slave  q,
    output logic [CW-1:0]      occupancy,
    output logic               overflow_error
);
    logic [CW-1:0] credits;
    logic          pop;
    logic          full;
    logic          empty;
    logic [DATA_WIDTH+FLAG_WIDTH-1:0] head;

    // Credits count free slots including ops still travelling down the pipe,
    // so a result slot always exists when an op reaches the final stage.
    assign q.in_ready   = (credits != '0);
    assign q.issue_fire = q.in_valid & q.in_ready;
    assign pop          = q.out_valid & q.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits <= CW'(DEPTH);
        end else if (q.issue_fire & ~pop) begin
            credits <= credits - CW'(1);
        end else if (pop & ~q.issue_fire) begin
            credits <= credits + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_error <= 1'b0;
        end else if (q.result_valid & full & ~pop) begin
            overflow_error <= 1'b1;
        end
    end

    fpu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH + FLAG_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (q.result_valid),
        .push_data ({q.result, q.result_flags}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (occupancy),
        .head      (head)
    );

    assign q.out_valid  = ~empty;
    assign q.out_result = head[DATA_WIDTH+FLAG_WIDTH-1:FLAG_WIDTH];
    assign q.out_flags  = head[FLAG_WIDTH-1:0];
endmodule

// File: tb/tb_fpu_result_queue.sv
// tb/tb_fpu_result_queue.sv - directed vector bench for fpu_result_queue
module tb_fpu_result_queue;
    import fpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] occupancy;
    logic       overflow_error;
    int         pass_cnt = 0;
    int         tot_cnt  = 0;

    fpu_result_queue_if #(.DATA_WIDTH(32), .FLAG_WIDTH(5)) qif ();

    fpu_result_queue dut (
        .clk            (clk),
        .reset          (reset),
        .q              (qif),
        .occupancy      (occupancy),
        .overflow_error (overflow_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        orr;
        logic        rv;
        logic [31:0] res;
        logic [4:0]  fl;
        logic        e_ir;
        logic        e_fire;
        logic        e_ov;
        logic [31:0] e_res;
        logic [4:0]  e_fl;
        logic [3:0]  e_occ;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle's inputs after the falling edge, then settle before sampling.
    task automatic drive(input logic iv, input logic orr, input logic rv,
                         input logic [31:0] res, input logic [4:0] fl);
        @(negedge clk);
        qif.in_valid     = iv;
        qif.out_ready    = orr;
        qif.result_valid = rv;
        qif.result       = res;
        qif.result_flags = fl;
        #1;
    endtask

    function automatic logic [4:0] op_flags(input int i);
        fpu_flags_t f;
        f = '0;
        if (i == 13) f.inexact = 1'b1;
        else if (i % 5 == 2) f.overflow = 1'b1;
        else if (i % 7 == 3) f.invalid = 1'b1;
        return f;
    endfunction

    initial begin
        int fires;
        int issued;
        int received;
        int cyc;
        logic        pv [3];
        int          pi [3];
        logic [36:0] expq [$];
        logic [36:0] e;

        qif.in_valid = 0; qif.out_ready = 0; qif.result_valid = 0;
        qif.result = '0; qif.result_flags = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", qif.in_ready, 1);
        chk("reset_out_valid", qif.out_valid, 0);
        chk("reset_out_result", qif.out_result, 0);
        chk("reset_out_flags", qif.out_flags, 0);
        chk("reset_occupancy", occupancy, 0);
        chk("reset_overflow", overflow_error, 0);

        //              iv orr rv res            fl        ir fire ov e_res          e_fl      occ
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b0, 1'b0, 32'h0,        5'b00000, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b1, 1'b0, 32'h0,        5'b00000, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h3F800000, 5'b00000, 1'b1, 1'b0, 1'b0, 32'h0,        5'b00000, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b0, 1'b1, 32'h3F800000, 5'b00000, 4'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b0, 1'b0, 32'h0,        5'b00000, 4'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b1, 1'b0, 32'h0,        5'b00000, 4'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h40490FDB, 5'b00001, 1'b1, 1'b1, 1'b0, 32'h0,        5'b00000, 4'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h7F800000, 5'b00010, 1'b1, 1'b1, 1'b1, 32'h40490FDB, 5'b00001, 4'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'hFFC00000, 5'b10000, 1'b1, 1'b0, 1'b1, 32'h40490FDB, 5'b00001, 4'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b0, 1'b1, 32'h7F800000, 5'b00010, 4'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b0, 1'b1, 32'hFFC00000, 5'b10000, 4'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b0, 1'b0, 32'h0,        5'b00000, 4'd0};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].iv, vecs[i].orr, vecs[i].rv, vecs[i].res, vecs[i].fl);
            chk($sformatf("v%0d_in_ready", i), qif.in_ready, vecs[i].e_ir);
            chk($sformatf("v%0d_issue_fire", i), qif.issue_fire, vecs[i].e_fire);
            chk($sformatf("v%0d_out_valid", i), qif.out_valid, vecs[i].e_ov);
            chk($sformatf("v%0d_occupancy", i), occupancy, vecs[i].e_occ);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_out_result", i), qif.out_result, vecs[i].e_res);
                chk($sformatf("v%0d_out_flags", i), qif.out_flags, vecs[i].e_fl);
            end
        end

        // Backpressure: credits run out after exactly DEPTH issues.
        fires = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 0, 0, 0);
            if (qif.issue_fire) fires++;
        end
        chk("bp_fire_count", fires, 8);
        chk("bp_in_ready_low", qif.in_ready, 0);
        for (int k = 0; k < 8; k++) drive(1, 0, 1, 32'h1000 + k, 5'(k));
        drive(1, 0, 0, 0, 0);
        chk("bp_full_occ", occupancy, 8);
        chk("bp_head", qif.out_result, 32'h1000);
        drive(1, 1, 0, 0, 0);
        chk("bp_pop_no_fire", qif.issue_fire, 0);
        drive(1, 0, 0, 0, 0);
        chk("bp_credit_back", qif.in_ready, 1);
        chk("bp_extra_fire", qif.issue_fire, 1);
        drive(0, 0, 1, 32'h2000, 5'h1F);
        chk("bp_in_ready_again_low", qif.in_ready, 0);

        // Overflow: forced push into a full FIFO is dropped and flagged.
        drive(0, 0, 1, 32'hDEAD, 5'h0A);
        chk("ovf_before", overflow_error, 0);
        chk("ovf_full", occupancy, 8);
        drive(0, 0, 0, 0, 0);
        chk("ovf_set", overflow_error, 1);
        chk("ovf_occ", occupancy, 8);
        chk("ovf_head", qif.out_result, 32'h1001);
        chk("ovf_head_flags", qif.out_flags, 5'd1);
        drive(0, 0, 0, 0, 0);
        chk("ovf_sticky", overflow_error, 1);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("ovf_reset_clear", overflow_error, 0);
        chk("ovf_reset_occ", occupancy, 0);

        // Simultaneous issue and pop at credits == 1.
        for (int k = 0; k < 7; k++) drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) drive(0, 0, 1, 32'h3000 + k, 0);
        drive(1, 1, 0, 0, 0);
        chk("sim_fire", qif.issue_fire, 1);
        chk("sim_out_valid", qif.out_valid, 1);
        drive(0, 0, 0, 0, 0);
        chk("sim_in_ready_kept", qif.in_ready, 1);
        chk("sim_occ", occupancy, 6);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 32'h3007, 0);
        chk("pp_occ_before", occupancy, 3);
        chk("pp_head", qif.out_result, 32'h3004);
        drive(0, 0, 0, 0, 0);
        chk("pp_occ_after", occupancy, 3);
        chk("pp_head_next", qif.out_result, 32'h3005);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("pp_drained_occ", occupancy, 0);
        chk("pp_drained_ready", qif.in_ready, 1);

        // Wrap-around stream through a 3-stage pipeline model with random backpressure.
        issued = 0; received = 0; cyc = 0;
        for (int s = 0; s < 3; s++) begin pv[s] = 0; pi[s] = 0; end
        while (received < 20 && cyc < 600) begin
            drive(issued < 20, 1'($urandom_range(0, 1)), pv[2],
                  32'h3F800000 + pi[2], op_flags(pi[2]));
            cyc++;
            if (qif.out_valid && qif.out_ready) begin
                e = expq.pop_front();
                chk($sformatf("wrap_result_%0d", received), qif.out_result, e[36:5]);
                chk($sformatf("wrap_flags_%0d", received), qif.out_flags, e[4:0]);
                received++;
            end
            if (pv[2]) expq.push_back({32'h3F800000 + pi[2], op_flags(pi[2])});
            pv[2] = pv[1]; pi[2] = pi[1];
            pv[1] = pv[0]; pi[1] = pi[0];
            pv[0] = qif.issue_fire; pi[0] = issued;
            if (qif.issue_fire) issued++;
        end
        chk("wrap_received", received, 20);
        drive(0, 0, 0, 0, 0);
        chk("wrap_occ", occupancy, 0);
        chk("wrap_in_ready", qif.in_ready, 1);

        // Reset mid-stream with three results queued.
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 32'h5000 + k, 0);
        drive(0, 0, 0, 0, 0);
        chk("mid_occ3", occupancy, 3);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("mid_out_valid", qif.out_valid, 0);
        chk("mid_occ0", occupancy, 0);
        chk("mid_in_ready", qif.in_ready, 1);
        drive(1, 0, 0, 0, 0);
        chk("mid_fire", qif.issue_fire, 1);
        drive(0, 0, 1, 32'hC0490FDB, 5'b00001);
        drive(0, 1, 0, 0, 0);
        chk("mid_rt_valid", qif.out_valid, 1);
        chk("mid_rt_result", qif.out_result, 32'hC0490FDB);
        chk("mid_rt_flags", qif.out_flags, 5'b00001);
        drive(0, 0, 0, 0, 0);
        chk("mid_rt_empty", occupancy, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
